// File: rtl/bus_dec_tmo.sv
// Address decoder for a single-master bus: priority slot select, response
// multiplexing, per-access timeout, and a sticky first-error capture register.
module bus_dec_tmo #(
  parameter int                 NSLV     = 10,
  parameter logic [NSLV*30-1:0] SLV_BASE = '0,
  parameter logic [NSLV*30-1:0] SLV_MASK = '0,
  parameter int                 TMO_CYC  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bus_stb,
  input  logic                 bus_we,
  input  logic [29:0]          bus_addr,
  output logic [31:0]          bus_din,
  output logic                 bus_ack,
  output logic                 bus_err,
  output logic [NSLV-1:0]      slv_stb,
  input  logic [NSLV*32-1:0]   slv_dout,
  input  logic [NSLV-1:0]      slv_ack,
  input  logic                 err_clr,
  output logic [29:0]          err_addr,
  output logic [3:0]           err_stat,
  output logic                 err_irq
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_WAIT  = 2'd1;
  localparam logic [1:0]  ST_ERR   = 2'd2;
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  logic [1:0]      state, state_nx;
  logic [15:0]     cnt, cnt_nx;
  logic [NSLV-1:0] hit, win_oh;
  logic            hit_any, win_ack, act, go_err, go_tmo;
  logic [31:0]     win_dout;

  // Descending scan so the lowest hitting slot is the one left standing.
  always_comb begin
    hit    = '0;
    win_oh = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      hit[i] = ((bus_addr ^ SLV_BASE[30*i +: 30]) & SLV_MASK[30*i +: 30]) == 30'd0;
      if (hit[i]) win_oh = NSLV'(1) << i;
    end
  end

  always_comb begin
    win_dout = 32'h0;
    for (int i = 0; i < NSLV; i++) begin
      if (win_oh[i]) win_dout = slv_dout[32*i +: 32];
    end
  end

  assign hit_any = |win_oh;
  assign win_ack = |(slv_ack & win_oh);
  assign act     = (state != ST_ERR);

  assign slv_stb = (bus_stb && act) ? win_oh : '0;
  assign bus_din = act ? win_dout : 32'h0;
  assign bus_err = (state == ST_ERR);
  assign bus_ack = bus_err || (bus_stb && act && win_ack);
  assign err_irq = err_stat[0];

  always_comb begin
    state_nx = ST_IDLE;
    cnt_nx   = 16'd0;
    go_err   = 1'b0;
    go_tmo   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus_stb && !hit_any) begin
          state_nx = ST_ERR;
          go_err   = 1'b1;
        end else if (bus_stb && !win_ack) begin
          state_nx = ST_WAIT;
          cnt_nx   = 16'd1;
        end
      end
      ST_WAIT: begin
        // A dropped strobe or a winner ack both end the access quietly.
        if (bus_stb && !win_ack) begin
          if (cnt == TMO_LAST) begin
            state_nx = ST_ERR;
            go_err   = 1'b1;
            go_tmo   = 1'b1;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = cnt + 16'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Only the first error is kept; later ones just raise the overflow flag
  // unless a clear lands in the same cycle, which frees the slot for them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr <= 30'd0;
      err_stat <= 4'd0;
    end else if (go_err) begin
      if (err_stat[0] && !err_clr) begin
        err_stat[3] <= 1'b1;
      end else begin
        err_addr <= bus_addr;
        err_stat <= {1'b0, bus_we, go_tmo, 1'b1};
      end
    end else if (err_clr) begin
      err_stat <= 4'd0;
    end
  end

endmodule

// File: tb/tb_bus_dec_tmo.sv
// Bench for bus_dec_tmo: directed scenarios plus randomized accesses checked
// against a transaction-level model of decode, timeout and error capture.
module tb_bus_dec_tmo;

  localparam int NSLV = 6;
  localparam int TMO  = 4;
  localparam logic [NSLV*30-1:0] BASE_P = {30'h20001000, 30'h30000000, 30'h21000000,
                                           30'h20000000, 30'h10000000, 30'h00000000};
  localparam logic [NSLV*30-1:0] MASK_P = {30'h3FFFF000, 30'h3FFF0000, 30'h3FFFFF00,
                                           30'h3F000000, 30'h3F000000, 30'h38000000};

  logic               clk = 1'b0;
  logic               rst_n, bus_stb, bus_we, err_clr;
  logic [29:0]        bus_addr;
  logic [31:0]        bus_din;
  logic               bus_ack, bus_err, err_irq;
  logic [NSLV-1:0]    slv_stb, slv_ack;
  logic [NSLV*32-1:0] slv_dout;
  logic [29:0]        err_addr;
  logic [3:0]         err_stat;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the error register
  logic        m_valid = 1'b0, m_ovf = 1'b0, m_we = 1'b0, m_tmo = 1'b0;
  logic [29:0] m_addr = 30'd0;

  bus_dec_tmo #(.NSLV(NSLV), .SLV_BASE(BASE_P), .SLV_MASK(MASK_P), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_din(bus_din), .bus_ack(bus_ack), .bus_err(bus_err), .slv_stb(slv_stb),
    .slv_dout(slv_dout), .slv_ack(slv_ack), .err_clr(err_clr), .err_addr(err_addr),
    .err_stat(err_stat), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int ref_win(input logic [29:0] a);
    for (int i = 0; i < NSLV; i++)
      if (((a ^ BASE_P[30*i +: 30]) & MASK_P[30*i +: 30]) == 30'd0) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic stb, input logic [29:0] a, input logic we,
                       input logic wack, input bit noise);
    int w;
    bus_stb  = stb;
    bus_addr = a;
    bus_we   = we;
    for (int i = 0; i < NSLV; i++) slv_dout[32*i +: 32] = $urandom;
    slv_ack = noise ? NSLV'($urandom) : '0;
    w = ref_win(a);
    if (w >= 0) slv_ack[w] = wack;
  endtask

  // Called at posedge+1 after inputs are driven; checks, clocks, updates model.
  task automatic do_cycle(input bit in_err, input bit exp_ack, input bit enter_err,
                          input bit tmo, input string tag);
    int w;
    logic [NSLV-1:0] e_stb;
    logic [31:0]     e_din;
    #3;
    w = ref_win(bus_addr);
    e_stb = '0;
    e_din = 32'h0;
    if (!in_err && w >= 0) begin
      e_din = slv_dout[32*w +: 32];
      if (bus_stb) e_stb[w] = 1'b1;
    end
    chk({tag, ".stb"},  32'(slv_stb), 32'(e_stb));
    chk({tag, ".ack"},  32'(bus_ack), 32'(exp_ack));
    chk({tag, ".err"},  32'(bus_err), 32'(in_err));
    chk({tag, ".din"},  bus_din, e_din);
    chk({tag, ".stat"}, 32'(err_stat), 32'({m_ovf, m_we, m_tmo, m_valid}));
    chk({tag, ".irq"},  32'(err_irq), 32'(m_valid));
    if (m_valid) chk({tag, ".eaddr"}, 32'(err_addr), 32'(m_addr));
    @(posedge clk);
    if (enter_err) begin
      if (m_valid && !err_clr) m_ovf = 1'b1;
      else begin
        m_addr = bus_addr; m_we = bus_we; m_tmo = tmo; m_valid = 1'b1; m_ovf = 1'b0;
      end
    end else if (err_clr) begin
      m_valid = 1'b0; m_ovf = 1'b0; m_we = 1'b0; m_tmo = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 30'($urandom), 1'b0, 1'b0, 1'b1);
      err_clr = 1'b0;
      do_cycle(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    end
  endtask

  // clr_mode: 0 never, 1 random, 2 only in the cycle that enters the error state
  task automatic run_txn(input logic [29:0] a, input logic we, input int lat,
                         input int clr_mode, input string tag);
    int w;
    bit entry;
    w = ref_win(a);
    if (w < 0) begin
      drive(1'b1, a, we, 1'b0, 1'b1);
      err_clr = (clr_mode == 2) || (clr_mode == 1 && $urandom_range(0, 4) == 0);
      do_cycle(1'b0, 1'b0, 1'b1, 1'b0, tag);
      drive(1'b1, a, we, 1'b0, 1'b1);
      err_clr = (clr_mode == 1 && $urandom_range(0, 4) == 0);
      do_cycle(1'b1, 1'b1, 1'b0, 1'b0, tag);
    end else begin
      for (int k = 0; k <= TMO; k++) begin
        if (k == TMO) begin
          drive(1'b1, a, we, 1'b0, 1'b1);
          err_clr = (clr_mode == 1 && $urandom_range(0, 4) == 0);
          do_cycle(1'b1, 1'b1, 1'b0, 1'b0, tag);
          break;
        end
        drive(1'b1, a, we, k == lat, 1'b1);
        entry = (k == TMO - 1) && (k != lat);
        err_clr = (clr_mode == 2 && entry) || (clr_mode == 1 && $urandom_range(0, 4) == 0);
        if (k == lat) begin
          do_cycle(1'b0, 1'b1, 1'b0, 1'b0, tag);
          break;
        end
        do_cycle(1'b0, 1'b0, entry, 1'b1, tag);
      end
    end
    err_clr = 1'b0;
  endtask

  initial begin
    logic [29:0] a;
    int s;
    rst_n = 1'b1; bus_stb = 1'b0; bus_we = 1'b0; bus_addr = 30'd0;
    slv_ack = '0; slv_dout = '0; err_clr = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst.ack",   32'(bus_ack),  32'd0);
    chk("rst.err",   32'(bus_err),  32'd0);
    chk("rst.stb",   32'(slv_stb),  32'd0);
    chk("rst.stat",  32'(err_stat), 32'd0);
    chk("rst.eaddr", 32'(err_addr), 32'd0);
    chk("rst.irq",   32'(err_irq),  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // RAM-like slot 0, immediate ack
    run_txn(30'h0000_0400, 1'b0, 0, 0, "ram_rd");
    // Overlapping slots 2 and 5: slot 2 must win
    run_txn(30'h2000_1234, 1'b0, 1, 0, "ovl");
    drive(1'b1, 30'h2000_1234, 1'b0, 1'b0, 1'b0);
    #3 chk("ovl.onehot", 32'(slv_stb), 32'h4);
    @(posedge clk); #1 idle(1);

    // Unmapped write
    run_txn(30'h0FC0_0000, 1'b1, 0, 0, "unm");
    chk("unm.stat2",  32'(err_stat), 32'h5);
    chk("unm.eaddr2", 32'(err_addr), 32'h0FC0_0000);
    chk("unm.irq2",   32'(err_irq),  32'd1);
    idle(1);
    drive(1'b0, 30'd0, 1'b0, 1'b0, 1'b0); err_clr = 1'b1;
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, "clr1");
    err_clr = 1'b0;
    chk("clr1.stat", 32'(err_stat), 32'd0);

    // Timeout, then late-but-in-time ack
    run_txn(30'h1000_0040, 1'b0, 99, 0, "tmo");
    chk("tmo.stat2", 32'(err_stat), 32'h3);
    idle(1);
    drive(1'b0, 30'd0, 1'b0, 1'b0, 1'b0); err_clr = 1'b1;
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, "clr2");
    err_clr = 1'b0;
    run_txn(30'h1000_0040, 1'b0, 3, 0, "late");
    chk("late.stat2", 32'(err_stat), 32'd0);

    // Strobe dropped mid-wait, then a fresh access must take the full timeout
    drive(1'b1, 30'h3000_0010, 1'b0, 1'b0, 1'b1); do_cycle(1'b0, 1'b0, 1'b0, 1'b0, "drop.c0");
    drive(1'b1, 30'h3000_0010, 1'b0, 1'b0, 1'b1); do_cycle(1'b0, 1'b0, 1'b0, 1'b0, "drop.c1");
    drive(1'b0, 30'h3000_0010, 1'b0, 1'b0, 1'b1); do_cycle(1'b0, 1'b0, 1'b0, 1'b0, "drop.c2");
    run_txn(30'h3000_0010, 1'b0, 99, 0, "drop.tmo");
    idle(1);
    drive(1'b0, 30'd0, 1'b0, 1'b0, 1'b0); err_clr = 1'b1;
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, "clr3");
    err_clr = 1'b0;

    // Two errors without clear, clear, then a third coincident with clear
    run_txn(30'h0FC0_0000, 1'b1, 0, 0, "e1");
    idle(1);
    run_txn(30'h3FFF_FFF0, 1'b0, 0, 0, "e2");
    chk("e2.stat2",  32'(err_stat), 32'hD);
    chk("e2.eaddr2", 32'(err_addr), 32'h0FC0_0000);
    idle(1);
    drive(1'b0, 30'd0, 1'b0, 1'b0, 1'b0); err_clr = 1'b1;
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, "clr4");
    err_clr = 1'b0;
    chk("clr4.stat", 32'(err_stat), 32'd0);
    chk("clr4.irq",  32'(err_irq),  32'd0);
    run_txn(30'h0FC0_0000, 1'b1, 0, 0, "e3a");
    run_txn(30'h0FC0_0010, 1'b0, 0, 2, "e3b");
    chk("e3b.stat2",  32'(err_stat), 32'h1);
    chk("e3b.eaddr2", 32'(err_addr), 32'h0FC0_0010);

    // Reset while waiting with cnt=2
    idle(1);
    drive(1'b1, 30'h1000_0080, 1'b0, 1'b0, 1'b0); do_cycle(1'b0, 1'b0, 1'b0, 1'b0, "rw.c0");
    drive(1'b1, 30'h1000_0080, 1'b0, 1'b0, 1'b0); do_cycle(1'b0, 1'b0, 1'b0, 1'b0, "rw.c1");
    drive(1'b1, 30'h1000_0080, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rw.ack",   32'(bus_ack),  32'd0);
    chk("rw.err",   32'(bus_err),  32'd0);
    chk("rw.stat",  32'(err_stat), 32'd0);
    chk("rw.eaddr", 32'(err_addr), 32'd0);
    m_valid = 1'b0; m_ovf = 1'b0; m_we = 1'b0; m_tmo = 1'b0; m_addr = 30'd0;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);
    run_txn(30'h1000_0080, 1'b0, 99, 0, "rw.post");

    // Randomized accesses
    for (int t = 0; t < 150; t++) begin
      s = $urandom_range(0, NSLV);
      if (s >= NSLV) a = 30'($urandom);
      else a = (BASE_P[30*s +: 30] & MASK_P[30*s +: 30]) |
               (30'($urandom) & ~MASK_P[30*s +: 30]);
      run_txn(a, 1'($urandom), $urandom_range(0, 6), 1, "rnd");
      idle($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_dec_tmo.md
BUS_DEC_TMO -- requirements
Module: bus_dec_tmo

Interface
REQ-001 Parameter NSLV, default 10, number of slave slots (1..16).
REQ-002 Parameter SLV_BASE, default all zero, NSLV*30-bit packed word-address bases, slot i at [30*i+29:30*i].
REQ-003 Parameter SLV_MASK, default all zero, NSLV*30-bit packed compare masks (1 = bit compared), same packing.
REQ-004 Parameter TMO_CYC, default 256, bus timeout in cycles (2..65535).
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 bus_stb  in  1  master strobe.
REQ-008 bus_we  in  1  master write enable.
REQ-009 bus_addr  in  30  master word address [31:2].
REQ-010 bus_din  out  32  read data to master.
REQ-011 bus_ack  out  1  acknowledge to master.
REQ-012 bus_err  out  1  error qualifier, valid only with bus_ack.
REQ-013 slv_stb  out  NSLV  per-slot strobe.
REQ-014 slv_dout  in  NSLV*32  packed slave read data, slot i at [32*i+31:32*i].
REQ-015 slv_ack  in  NSLV  per-slot acknowledge.
REQ-016 err_clr  in  1  single-cycle clear of error status.
REQ-017 err_addr  out  30  captured address of first error.
REQ-018 err_stat  out  4  {ovf, we, tmo(1)/unmapped(0), valid}.
REQ-019 err_irq  out  1  interrupt request, equals err_stat[0].

Function
REQ-020 Slot i hits when ((bus_addr XOR base_i) AND mask_i) == 0; lowest hitting index wins; none hitting = unmapped.
REQ-021 slv_stb[i] = bus_stb AND winning slot i AND state != ERR; at most one bit set.
REQ-022 bus_din = slv_dout of winning slot in IDLE/WAIT, 32'h0 in ERR or when unmapped.
REQ-023 States IDLE, WAIT, ERR; 16-bit counter cnt.
REQ-024 IDLE, no bus_stb: stay, cnt=0.
REQ-025 IDLE, bus_stb, hit, slv_ack of winner = 1: bus_ack=1 combinationally, stay IDLE.
REQ-026 IDLE, bus_stb, hit, no ack: go WAIT, cnt=1.
REQ-027 IDLE, bus_stb, unmapped: go ERR (error ack in cycle 1 after strobe).
REQ-028 WAIT, winner ack: bus_ack=1 combinationally, go IDLE, cnt=0.
REQ-029 WAIT, bus_stb dropped: go IDLE without ack, no error logged.
REQ-030 WAIT, no ack, cnt == TMO_CYC-1: go ERR; else cnt+1; error ack lands in cycle TMO_CYC counted from first strobe cycle 0.
REQ-031 ERR: bus_ack=1, bus_err=1, bus_din=0, slv_stb=0 for exactly one cycle, then IDLE unconditionally.
REQ-032 bus_err=0 whenever state != ERR; bus_ack=0 in ERR never suppressed.
REQ-033 Error capture on entry to ERR: if valid=0, load err_addr, we, tmo, set valid; if valid=1, keep captured data, set ovf.
REQ-034 err_clr clears valid and ovf; err_clr coincident with ERR entry: new error captured, ovf=0.
REQ-035 Slave ack from non-winning slots ignored.

Reset
REQ-036 rst_n low forces state IDLE, cnt=0, err_addr=0, err_stat=0 immediately; bus_ack, bus_err, slv_stb follow combinationally (0 with bus_stb low).
REQ-037 Reset mid-WAIT abandons the cycle without ack or error.

Verification
REQ-038 Slot 0 base 0x0000000 mask 0x38000000 (RAM-like), read 0x00001000 with slv_ack[0] same cycle -> bus_ack cycle 0, bus_din = slv_dout[0], bus_err=0.
REQ-039 Address hitting slots 2 and 5 -> only slv_stb[2] asserts, data from slot 2.
REQ-040 Write to unmapped 0x3F000000 -> bus_ack=bus_err=1 in cycle 1, err_stat=4'b0101, err_addr=0x3F000000>>2, err_irq=1.
REQ-041 TMO_CYC=4, mapped slave never acks -> slv_stb high cycles 0..3, error ack cycle 4 only, err_stat=4'b0011; slave ack at cycle 3 instead -> normal ack, no error.
REQ-042 Two errors without clear -> err_addr holds first, ovf=1; err_clr pulse -> err_stat=0, err_irq=0; clear coincident with third error -> third captured.
REQ-043 rst_n low during WAIT cnt=2 -> no ack, state IDLE, next strobe times out after full TMO_CYC.
